// File: rtl/mmio_pwm_timer.sv
// Memory-mapped microsecond/millisecond timer and 3-channel PWM on the dmem bus.
// The 32-byte register window returns registered load data one cycle after the request.
module mmio_pwm_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int unsigned CLK_HZ    = 12_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_funct3,
  input  logic        i_dmem_wren,
  input  logic [31:0] i_dmem_address,
  input  logic [31:0] i_dmem_data_in,
  output logic [31:0] o_dmem_data_out,
  output logic        o_hit,
  output logic        o_red,
  output logic        o_green,
  output logic        o_blue
);

  localparam int unsigned Div = CLK_HZ / 1_000_000;
  localparam int unsigned PscW = $clog2(Div);
  localparam logic [PscW-1:0] PscLast = PscW'(Div - 1);

  logic            r_en;
  logic [31:0]     r_micros;
  logic [31:0]     r_millis;
  logic [15:0]     r_period;
  logic [15:0]     r_duty_r;
  logic [15:0]     r_duty_g;
  logic [15:0]     r_duty_b;
  logic [PscW-1:0] r_psc;
  logic [9:0]      r_us_sub;
  logic [15:0]     r_pwm_cnt;

  logic        w_in_win;
  logic [2:0]  w_off;
  logic [1:0]  w_lane;
  logic        w_st_ok;
  logic        w_we;
  logic [15:0] w_wmask;
  logic [15:0] w_wdata;
  logic [15:0] w_src16;
  logic [15:0] w_merged;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_rd_ext;
  logic [31:0] w_rd_next;
  logic        w_unused_data;

  assign w_in_win = (i_dmem_address[31:5] == BASE_ADDR[31:5]);
  assign w_off    = i_dmem_address[4:2];
  assign w_lane   = i_dmem_address[1:0];
  // All registers are at most 16 bits wide, so store data above bit 15 never lands.
  assign w_unused_data = ^i_dmem_data_in[31:16];

  always_comb begin
    w_st_ok = 1'b0;
    w_wmask = 16'h0000;
    w_wdata = 16'h0000;
    case (i_funct3)
      3'b000: begin
        w_st_ok = 1'b1;
        w_wdata = {2{i_dmem_data_in[7:0]}};
        w_wmask = (w_lane == 2'd0) ? 16'h00FF : (w_lane == 2'd1) ? 16'hFF00 : 16'h0000;
      end
      3'b001: begin
        w_st_ok = ~w_lane[0];
        w_wdata = i_dmem_data_in[15:0];
        w_wmask = w_lane[1] ? 16'h0000 : 16'hFFFF;
      end
      3'b010: begin
        w_st_ok = (w_lane == 2'd0);
        w_wdata = i_dmem_data_in[15:0];
        w_wmask = 16'hFFFF;
      end
      default: ;
    endcase
  end

  assign w_we = i_dmem_wren & w_in_win & w_st_ok;

  always_comb begin
    w_src16 = 16'h0000;
    w_word  = 32'h0000_0000;
    case (w_off)
      3'd0: begin w_src16 = {15'b0, r_en}; w_word = {31'b0, r_en}; end
      3'd1: w_word = r_micros;
      3'd2: w_word = r_millis;
      3'd3: begin w_src16 = r_period; w_word = {16'b0, r_period}; end
      3'd4: begin w_src16 = r_duty_r; w_word = {16'b0, r_duty_r}; end
      3'd5: begin w_src16 = r_duty_g; w_word = {16'b0, r_duty_g}; end
      3'd6: begin w_src16 = r_duty_b; w_word = {16'b0, r_duty_b}; end
      default: ;
    endcase
  end

  assign w_merged = (w_src16 & ~w_wmask) | (w_wdata & w_wmask);

  always_comb begin
    w_byte = 8'h00;
    unique case (w_lane)
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
    endcase
    w_half   = w_lane[1] ? w_word[31:16] : w_word[15:0];
    w_rd_ext = 32'h0000_0000;
    case (i_funct3)
      3'b000: w_rd_ext = {{24{w_byte[7]}}, w_byte};
      3'b100: w_rd_ext = {24'b0, w_byte};
      3'b001: if (!w_lane[0]) w_rd_ext = {{16{w_half[15]}}, w_half};
      3'b101: if (!w_lane[0]) w_rd_ext = {16'b0, w_half};
      3'b010: if (w_lane == 2'd0) w_rd_ext = w_word;
      default: ;
    endcase
  end

  assign w_rd_next = (!i_dmem_wren && w_in_win) ? w_rd_ext : 32'h0000_0000;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_en            <= 1'b0;
      r_micros        <= 32'h0;
      r_millis        <= 32'h0;
      r_period        <= 16'h0;
      r_duty_r        <= 16'h0;
      r_duty_g        <= 16'h0;
      r_duty_b        <= 16'h0;
      r_psc           <= '0;
      r_us_sub        <= 10'd0;
      r_pwm_cnt       <= 16'h0;
      o_dmem_data_out <= 32'h0;
      o_hit           <= 1'b0;
      o_red           <= 1'b0;
      o_green         <= 1'b0;
      o_blue          <= 1'b0;
    end else begin
      o_dmem_data_out <= w_rd_next;
      o_hit           <= w_in_win;

      if (w_we) begin
        case (w_off)
          3'd0: r_en     <= w_merged[0];
          3'd3: r_period <= w_merged;
          3'd4: r_duty_r <= w_merged;
          3'd5: r_duty_g <= w_merged;
          3'd6: r_duty_b <= w_merged;
          default: ;
        endcase
      end

      if (r_en) begin
        if (r_psc == PscLast) begin
          r_psc    <= '0;
          r_micros <= r_micros + 32'd1;
          if (r_us_sub == 10'd999) begin
            r_us_sub <= 10'd0;
            r_millis <= r_millis + 32'd1;
          end else begin
            r_us_sub <= r_us_sub + 10'd1;
          end
        end else begin
          r_psc <= r_psc + 1'b1;
        end
      end

      // A PERIOD store restarts the PWM frame at the store edge.
      if (w_we && (w_off == 3'd3)) begin
        r_pwm_cnt <= 16'h0;
      end else if (r_en) begin
        if ((r_period == 16'h0) || (r_pwm_cnt >= r_period - 16'd1)) r_pwm_cnt <= 16'h0;
        else r_pwm_cnt <= r_pwm_cnt + 16'd1;
      end

      o_red   <= r_en && (r_period != 16'h0) && (r_pwm_cnt < r_duty_r);
      o_green <= r_en && (r_period != 16'h0) && (r_pwm_cnt < r_duty_g);
      o_blue  <= r_en && (r_period != 16'h0) && (r_pwm_cnt < r_duty_b);
    end
  end

endmodule

// File: tb/tb_mmio_pwm_timer.sv
// Self-checking bench for mmio_pwm_timer: expected values are queued as each access
// or measurement window is issued and popped when the DUT result is sampled.
module tb_mmio_pwm_timer;

  localparam logic [31:0] Base = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  funct3 = 3'b010;
  logic        wren = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        hit, red, green, blue;

  logic [31:0] exp_q[$];
  logic [31:0] obs, e;
  logic        h;
  int          total = 0;
  int          bad = 0;

  mmio_pwm_timer #(.BASE_ADDR(Base), .CLK_HZ(12_000_000)) dut (
    .i_clk(clk), .i_reset(reset), .i_funct3(funct3), .i_dmem_wren(wren),
    .i_dmem_address(addr), .i_dmem_data_in(wdata), .o_dmem_data_out(rdata),
    .o_hit(hit), .o_red(red), .o_green(green), .o_blue(blue)
  );

  always #5 clk = ~clk;

  // Callers sit at posedge+1; each access occupies exactly one clock edge.
  task automatic bus_wr(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    wren = 1'b1; addr = a; funct3 = f3; wdata = d;
    @(posedge clk); #1;
    wren = 1'b0; addr = 32'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [2:0] f3,
                        output logic [31:0] d, output logic hh);
    wren = 1'b0; addr = a; funct3 = f3;
    @(posedge clk); #1;
    d = rdata; hh = hit; addr = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus_wr(Base + 32'h0C, 3'b010, 32'd4);
    bus_wr(Base + 32'h10, 3'b010, 32'd4);
    bus_wr(Base + 32'h00, 3'b010, 32'd1);
    repeat (50) @(posedge clk); #1;
    total++;
    if (red !== 1'b1) begin bad++; $display("FAIL reset_pre_red got=%b exp=1", red); end
    // Reset lands together with a store; the store must be dropped.
    reset = 1'b1; wren = 1'b1; addr = Base + 32'h14; funct3 = 3'b010; wdata = 32'd5;
    @(posedge clk); #1;
    wren = 1'b0; addr = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({rdata, hit, red, green, blue} !== 36'h0) begin
      bad++; $display("FAIL reset_outs got=%h/%b%b%b%b exp=0", rdata, hit, red, green, blue);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 8; i++) begin
      bus_rd(Base + 32'(i * 4), 3'b010, obs, h);
      e = exp_q.pop_front();
      total++;
      if (obs !== e || h !== 1'b1) begin
        bad++; $display("FAIL reset_reg%0d got=%h hit=%b exp=%h hit=1", i, obs, h, e);
      end
    end
  endtask

  task automatic test_counters();
    do_reset();
    bus_wr(Base + 32'h00, 3'b010, 32'd1);
    repeat (11) @(posedge clk); #1;
    exp_q.push_back(32'd0);
    bus_rd(Base + 32'h04, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL micros_11 got=%0d exp=%0d", obs, e); end
    exp_q.push_back(32'd1);
    bus_rd(Base + 32'h04, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL micros_12 got=%0d exp=%0d", obs, e); end
    exp_q.push_back(32'd0);
    bus_rd(Base + 32'h08, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL millis_early got=%0d exp=%0d", obs, e); end
    repeat (11986) @(posedge clk); #1;
    exp_q.push_back(32'd1000);
    bus_rd(Base + 32'h04, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL micros_12000 got=%0d exp=%0d", obs, e); end
    exp_q.push_back(32'd1);
    bus_rd(Base + 32'h08, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL millis_1 got=%0d exp=%0d", obs, e); end
  endtask

  task automatic count_rgb(input int n, output int cr, output int cg, output int cb);
    cr = 0; cg = 0; cb = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cr += int'(red); cg += int'(green); cb += int'(blue);
    end
  endtask

  task automatic test_pwm();
    int cr, cg, cb;
    do_reset();
    bus_wr(Base + 32'h0C, 3'b010, 32'd10);
    bus_wr(Base + 32'h10, 3'b010, 32'd3);
    bus_wr(Base + 32'h14, 3'b010, 32'd10);
    bus_wr(Base + 32'h18, 3'b010, 32'd0);
    bus_wr(Base + 32'h00, 3'b010, 32'd1);
    repeat (20) @(posedge clk); #1;
    exp_q.push_back({8'd0, 8'd30, 8'd100, 8'd0});
    count_rgb(100, cr, cg, cb);
    e = exp_q.pop_front(); total++;
    if ({8'd0, 8'(cr), 8'(cg), 8'(cb)} !== e) begin
      bad++; $display("FAIL pwm_3_10_0 got=%0d/%0d/%0d exp=30/100/0", cr, cg, cb);
    end
    bus_wr(Base + 32'h10, 3'b010, 32'd7);
    repeat (20) @(posedge clk); #1;
    exp_q.push_back({8'd0, 8'd70, 8'd100, 8'd0});
    count_rgb(100, cr, cg, cb);
    e = exp_q.pop_front(); total++;
    if ({8'd0, 8'(cr), 8'(cg), 8'(cb)} !== e) begin
      bad++; $display("FAIL pwm_duty7 got=%0d/%0d/%0d exp=70/100/0", cr, cg, cb);
    end
    bus_wr(Base + 32'h0C, 3'b010, 32'd0);
    repeat (3) @(posedge clk); #1;
    exp_q.push_back(32'd0);
    count_rgb(20, cr, cg, cb);
    e = exp_q.pop_front(); total++;
    if (32'(cr + cg + cb) !== e) begin
      bad++; $display("FAIL pwm_period0 got=%0d exp=%0d", cr + cg + cb, e);
    end
  endtask

  task automatic test_lanes();
    logic [2:0]  f3s[9]  = '{3'b000, 3'b101, 3'b001, 3'b101, 3'b000, 3'b100, 3'b000,
                             3'b010, 3'b011};
    logic [7:0]  offs[9] = '{8'h11, 8'h10, 8'h14, 8'h14, 8'h14, 8'h15, 8'h15, 8'h16, 8'h14};
    logic [31:0] exps[9] = '{32'hFFFF_FFFF, 32'h0000_FF34, 32'hFFFF_8001, 32'h0000_8001,
                             32'h0000_0001, 32'h0000_0080, 32'hFFFF_FF80, 32'h0, 32'h0};
    do_reset();
    bus_wr(Base + 32'h10, 3'b010, 32'hA5A5_1234);
    bus_wr(Base + 32'h11, 3'b000, 32'h0000_00FF);
    bus_wr(Base + 32'h14, 3'b010, 32'h0000_8001);
    bus_wr(Base + 32'h0C, 3'b010, 32'hDEAD_BEEF);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(exps[i]);
      bus_rd(Base + 32'(offs[i]), f3s[i], obs, h);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++; $display("FAIL lane_%0d off=%h f3=%b got=%h exp=%h", i, offs[i], f3s[i], obs, e);
      end
    end
    exp_q.push_back(32'h0000_BEEF);
    bus_rd(Base + 32'h0C, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL period_upper got=%h exp=%h", obs, e); end
  endtask

  task automatic test_illegal();
    do_reset();
    bus_wr(Base + 32'h0C, 3'b010, 32'h0000_0055);
    bus_wr(Base + 32'h0D, 3'b001, 32'h0000_1234);
    bus_wr(Base + 32'h20, 3'b010, 32'hFFFF_FFFF);
    bus_wr(Base + 32'h0E, 3'b010, 32'h0000_7777);
    bus_wr(Base + 32'h0C, 3'b100, 32'h0000_6666);
    bus_wr(Base + 32'h04, 3'b010, 32'h0000_0099);
    exp_q.push_back(32'h0000_0055);
    bus_rd(Base + 32'h0C, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e || h !== 1'b1) begin
      bad++; $display("FAIL illegal_period got=%h hit=%b exp=%h hit=1", obs, h, e);
    end
    exp_q.push_back(32'h0);
    bus_rd(Base + 32'h00, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL illegal_ctrl got=%h exp=%h", obs, e); end
    exp_q.push_back(32'h0);
    bus_rd(Base + 32'h04, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL ro_micros got=%h exp=%h", obs, e); end
    exp_q.push_back(32'h0);
    bus_rd(Base + 32'h20, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e || h !== 1'b0) begin
      bad++; $display("FAIL out_of_window got=%h hit=%b exp=%h hit=0", obs, h, e);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    bus_wr(Base + 32'h0C, 3'b010, 32'd10);
    bus_wr(Base + 32'h14, 3'b010, 32'd10);
    bus_wr(Base + 32'h00, 3'b010, 32'd1);
    repeat (689) @(posedge clk); #1;
    total++;
    if (green !== 1'b1) begin bad++; $display("FAIL freeze_green_on got=%b exp=1", green); end
    bus_wr(Base + 32'h00, 3'b010, 32'd0);
    exp_q.push_back(32'd57);
    bus_rd(Base + 32'h04, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL freeze_57 got=%0d exp=%0d", obs, e); end
    repeat (30) @(posedge clk); #1;
    total++;
    if ({red, green, blue} !== 3'b000) begin
      bad++; $display("FAIL freeze_rgb got=%b%b%b exp=000", red, green, blue);
    end
    exp_q.push_back(32'd57);
    bus_rd(Base + 32'h04, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL freeze_hold got=%0d exp=%0d", obs, e); end
    bus_wr(Base + 32'h00, 3'b010, 32'd1);
    repeat (120) @(posedge clk); #1;
    exp_q.push_back(32'd67);
    bus_rd(Base + 32'h04, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL resume_67 got=%0d exp=%0d", obs, e); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_wr(Base + 32'h18, 3'b010, 32'h0000_1111);
    exp_q.push_back(32'h0000_1111);
    bus_rd(Base + 32'h18, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL b2b_sw got=%h exp=%h", obs, e); end
    bus_wr(Base + 32'h1A, 3'b001, 32'h0000_FFFF);
    bus_wr(Base + 32'h18, 3'b000, 32'h0000_0022);
    exp_q.push_back(32'h0000_1122);
    bus_rd(Base + 32'h18, 3'b010, obs, h);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL b2b_sb got=%h exp=%h", obs, e); end
  endtask

  initial begin
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    test_reset();
    test_counters();
    test_pwm();
    test_lanes();
    test_illegal();
    test_freeze();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
